// File: rtl/snake_pkg.sv
// snake_pkg: one-hot direction encodings and the opposite-direction helper shared across the snake design
package snake_pkg;
  typedef logic [3:0] dir_t;
  localparam dir_t DIR_UP    = 4'b0001;
  localparam dir_t DIR_DOWN  = 4'b0010;
  localparam dir_t DIR_LEFT  = 4'b0100;
  localparam dir_t DIR_RIGHT = 4'b1000;
  function automatic dir_t opposite(input dir_t d);
    return {d[2], d[3], d[0], d[1]};
  endfunction
endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-FF synchroniser, debounce counter and one-cycle fall pulse for an active-low key (clk_i, reset_i, key in; fall out)
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 50_000,
  parameter int CNT_W           = 16
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic key,
  output logic fall
);
  logic s1, s2, stable, stable_d;
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s1       <= 1'b1;
      s2       <= 1'b1;
      stable   <= 1'b1;
      stable_d <= 1'b1;
      cnt      <= '0;
    end else begin
      s1       <= key;
      s2       <= s1;
      stable_d <= stable;
      if (s2 == stable) cnt <= '0;
      else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable <= s2;
        cnt    <= '0;
      end else cnt <= cnt + 1'b1;
    end
  end
  assign fall = stable_d & ~stable;
endmodule

// File: rtl/dir_input_ctrl.sv
// dir_input_ctrl: debounced KEY_0..3 (active-low R/L/D/U) turn requests into a 2-deep queue, popped into direction_o on step_i; clear_i restarts; press_o pulses per press; q_count_o shows occupancy
module dir_input_ctrl
  import snake_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50_000,
  parameter int CNT_W           = 16
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       KEY_0,
  input  logic       KEY_1,
  input  logic       KEY_2,
  input  logic       KEY_3,
  input  logic       step_i,
  input  logic       clear_i,
  output dir_t       direction_o,
  output logic       press_o,
  output logic [1:0] q_count_o
);
  logic [3:0] keys, fall;
  dir_t q0, q1, req, tail;
  logic push, pop;
  assign keys = {KEY_3, KEY_2, KEY_1, KEY_0};
  for (genvar g = 0; g < 4; g++) begin : g_key
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db (
      .clk_i  (clk_i),
      .reset_i(reset_i),
      .key    (keys[g]),
      .fall   (fall[g])
    );
  end
  always_comb begin
    req  = fall[3] ? DIR_UP : fall[2] ? DIR_DOWN : fall[1] ? DIR_LEFT : DIR_RIGHT;
    tail = q_count_o == 2'd2 ? q1 : q_count_o == 2'd1 ? q0 : direction_o;
    push = |fall && req != tail && req != opposite(tail);
    pop  = step_i && q_count_o != 2'd0;
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      direction_o <= DIR_RIGHT;
      q_count_o   <= 2'd0;
      press_o     <= 1'b0;
      q0          <= DIR_RIGHT;
      q1          <= DIR_RIGHT;
    end else begin
      press_o <= |fall;
      if (clear_i) begin
        direction_o <= DIR_RIGHT;
        q_count_o   <= 2'd0;
      end else begin
        if (pop) direction_o <= q0;
        q0 <= pop ? (q_count_o == 2'd2 ? q1 : req) : (push && q_count_o == 2'd0 ? req : q0);
        if (push && (pop ? q_count_o == 2'd2 : q_count_o == 2'd1)) q1 <= req;
        q_count_o <= pop && !push ? q_count_o - 2'd1 :
                     push && !pop && q_count_o != 2'd2 ? q_count_o + 2'd1 : q_count_o;
      end
    end
  end
endmodule
